// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and defaults that the receiver uses too.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_transmitter_if.sv
// Host-side byte handshake into the UART transmitter holding register.
interface uart_transmitter_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = UART_DATA_BITS
);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_transmitter.sv
// UART frame serialiser: start, LSB-first data, optional parity, 1-2 stop bits.
// A one-entry holding register lets the next frame start on the same tick as the last stop ends.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = UART_DATA_BITS,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tx_tick,
  uart_transmitter_if.slave  host,
  output logic               tx,
  output logic               tx_busy,
  output logic               tx_done
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             ODD       = 1'(PARITY_ODD);

  tx_state_t            state;
  logic [CNT_W-1:0]     sample_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] hold;
  logic                 hold_full;
  logic                 parity_bit;

  logic accept;
  logic bit_end;
  logic load;

  assign host.tx_ready = ~hold_full;
  assign accept        = host.tx_valid & ~hold_full;
  assign bit_end       = tx_tick & (sample_cnt == CNT_LAST);
  assign tx_busy       = (state != IDLE);

  // Load from hold either from IDLE or exactly at the end of the final stop bit (no gap).
  assign load = hold_full &
                ((state == IDLE) |
                 ((state == STOP) & bit_end & (stop_cnt == STOP_LAST)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      shift_reg  <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      if (accept) begin
        hold      <= host.tx_data;
        hold_full <= 1'b1;
      end

      if ((state != IDLE) && tx_tick) begin
        if (sample_cnt != CNT_LAST) begin
          sample_cnt <= sample_cnt + CNT_W'(1);
        end else begin
          sample_cnt <= '0;
          case (state)
            START: begin
              state     <= DATA;
              bit_cnt   <= '0;
              tx        <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
            DATA: begin
              if (bit_cnt != BIT_LAST) begin
                bit_cnt   <= bit_cnt + BIT_W'(1);
                tx        <= shift_reg[0];
                shift_reg <= shift_reg >> 1;
              end else if (PARITY_EN != 0) begin
                state <= PARITY;
                tx    <= parity_bit;
              end else begin
                state    <= STOP;
                stop_cnt <= 1'b0;
                tx       <= 1'b1;
              end
            end
            PARITY: begin
              state    <= STOP;
              stop_cnt <= 1'b0;
              tx       <= 1'b1;
            end
            STOP: begin
              if (stop_cnt != STOP_LAST) begin
                stop_cnt <= 1'b1;
              end else begin
                state   <= IDLE;
                tx      <= 1'b1;
                tx_done <= 1'b1;
              end
            end
            default: begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          endcase
        end
      end

      // Takes priority over the STOP->IDLE transition above when a byte is waiting.
      if (load) begin
        state      <= START;
        sample_cnt <= '0;
        shift_reg  <= hold;
        parity_bit <= (^hold) ^ ODD;
        hold_full  <= 1'b0;
        tx         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Three transmitter configurations checked every cycle against a frame/tick-position model,
// plus directed frames whose serial bits and timing are pinned to hand-computed values.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_tick = 1'b0;
  logic [2:0] valid_drv = '0;
  logic [7:0] data_drv [3];

  wire [2:0] tx_w;
  wire [2:0] ready_w;
  wire [2:0] busy_w;
  wire [2:0] done_w;

  int checks = 0;
  int errors = 0;
  int tick_total = 0;
  int tick_div = 4;
  int tick_ph = 0;
  bit tick_rand = 1'b0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tick_rand) begin
      tx_tick = ($urandom_range(0, 2) == 0);
    end else begin
      tick_ph = (tick_ph + 1) % tick_div;
      tx_tick = (tick_ph == 0);
    end
  end

  always @(posedge clk) if (tx_tick) tick_total <= tick_total + 1;

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int unsigned DB = (g == 2) ? 5 : 8;
    localparam int unsigned OS = (g == 2) ? 4 : 16;
    localparam int unsigned PE = (g == 0) ? 0 : 1;
    localparam int unsigned PO = (g == 2) ? 1 : 0;
    localparam int unsigned SB = (g == 1) ? 2 : 1;
    localparam int NBITS = 1 + DB + PE + SB;

    uart_transmitter_if #(.DATA_BITS(DB)) bus ();
    assign bus.tx_data  = data_drv[g][DB-1:0];
    assign bus.tx_valid = valid_drv[g];
    assign ready_w[g]   = bus.tx_ready;

    uart_transmitter #(
      .DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY_EN(PE), .PARITY_ODD(PO), .STOP_BITS(SB)
    ) dut (
      .clk(clk), .reset_n(reset_n), .tx_tick(tx_tick), .host(bus.slave),
      .tx(tx_w[g]), .tx_busy(busy_w[g]), .tx_done(done_w[g])
    );

    function automatic logic [11:0] frame_of(input logic [7:0] d);
      logic [11:0] f;
      logic p;
      f = '1;
      f[0] = 1'b0;
      p = (PO != 0);
      for (int i = 0; i < int'(DB); i++) begin
        f[1+i] = d[i];
        p = p ^ d[i];
      end
      if (PE != 0) f[1+DB] = p;
      return f;
    endfunction

    logic [7:0]  m_pend[$];
    logic [11:0] m_bits;
    int          m_tpos;
    bit          m_active;
    bit          m_done;

    // Line model: a frame is NBITS bits of OS ticks each, counted from the edge it starts on.
    always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        m_pend.delete();
        m_active = 1'b0;
        m_tpos   = 0;
        m_done   = 1'b0;
        m_bits   = '1;
      end else begin
        bit had_pend;
        had_pend = (m_pend.size() != 0);
        m_done = 1'b0;
        if (m_active && tx_tick) begin
          m_tpos++;
          if (m_tpos == NBITS * int'(OS)) begin
            m_active = 1'b0;
            m_done   = 1'b1;
          end
        end
        if (!m_active && had_pend) begin
          m_bits   = frame_of(m_pend.pop_front());
          m_active = 1'b1;
          m_tpos   = 0;
        end
        if (valid_drv[g] && !had_pend) m_pend.push_back(data_drv[g]);
      end
    end

    always @(negedge clk) begin
      if (reset_n) begin
        logic [3:0] act, expv;
        act  = {tx_w[g], ready_w[g], busy_w[g], done_w[g]};
        expv = {m_active ? m_bits[m_tpos / int'(OS)] : 1'b1,
                m_pend.size() == 0, m_active, m_done};
        checks++;
        if (act !== expv) begin
          errors++;
          $display("FAIL cfg%0d line t=%0t tx/rdy/busy/done got %b expected %b", g, $time, act, expv);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int os_of(input int k);
    return (k == 2) ? 4 : 16;
  endfunction

  task automatic offer(input int k, input logic [7:0] d);
    int cyc = 0;
    while (!ready_w[k] && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk("offer_ready", int'(ready_w[k]), 1);
    valid_drv[k] = 1'b1;
    data_drv[k]  = d;
    @(negedge clk);
    valid_drv[k] = 1'b0;
  endtask

  task automatic wait_fall(input int k, output int cyc);
    cyc = 0;
    while (tx_w[k] && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("tx_fall", int'(tx_w[k]), 0);
  endtask

  // Sends one byte from idle and samples each serial bit at its middle tick.
  task automatic measure(input int k, input logic [7:0] d, input int nb,
                         output logic [11:0] bits, output int tdone, output int lat);
    int os, t0, f, cyc;
    logic [11:0] seen;
    os = os_of(k);
    bits = '1;
    seen = '0;
    tdone = -1;
    offer(k, d);
    wait_fall(k, lat);
    t0 = tick_total;
    cyc = 0;
    while (tdone < 0 && cyc < 20000) begin
      f = tick_total - t0;
      for (int i = 0; i < nb; i++) begin
        if (!seen[i] && f >= i * os + os / 2) begin
          bits[i] = tx_w[k];
          seen[i] = 1'b1;
        end
      end
      if (done_w[k]) tdone = f;
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", int'(tdone >= 0), 1);
  endtask

  initial begin
    logic [11:0] bits;
    int tdone, lat, cyc, nd;
    for (int k = 0; k < 3; k++) data_drv[k] = '0;

    repeat (3) @(negedge clk);
    chk("reset_tx", int'(tx_w), 7);
    chk("reset_ready", int'(ready_w), 7);
    chk("reset_busy", int'(busy_w), 0);
    chk("reset_done", int'(done_w), 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0xA5
    measure(0, 8'hA5, 10, bits, tdone, lat);
    chk("a5_latency", lat, 1);
    chk("a5_bits", int'(bits[9:0]), 10'b1101001010);
    chk("a5_ticks", tdone, 160);
    @(negedge clk);
    chk("a5_done_single", int'(done_w[0]), 0);
    chk("a5_busy_after", int'(busy_w[0]), 0);

    // back-to-back 0x00 then 0xFF
    offer(0, 8'h00);
    wait_fall(0, lat);
    offer(0, 8'hFF);
    chk("b2b_ready_low", int'(ready_w[0]), 0);
    cyc = 0;
    while (!done_w[0] && cyc < 3000) begin @(negedge clk); cyc++; end
    chk("b2b_done1", int'(done_w[0]), 1);
    chk("b2b_start_same_edge", int'(tx_w[0]), 0);
    chk("b2b_ready_back", int'(ready_w[0]), 1);
    chk("b2b_busy", int'(busy_w[0]), 1);
    @(negedge clk);
    nd = 0; cyc = 0;
    while (busy_w[0] && cyc < 3000) begin
      if (done_w[0]) nd++;
      @(negedge clk);
      cyc++;
    end
    if (done_w[0]) nd++;
    chk("b2b_done2", nd, 1);

    // parity even, two stop bits
    measure(1, 8'h07, 12, bits, tdone, lat);
    chk("par_even_07", int'(bits[9]), 1);
    chk("stop2_bits", int'(bits[11:10]), 3);
    chk("stop2_ticks_07", tdone, 192);
    repeat (2) @(negedge clk);
    measure(1, 8'h55, 12, bits, tdone, lat);
    chk("par_even_55_frame", int'(bits), 12'b110010101010);
    chk("stop2_ticks_55", tdone, 192);

    // 5 data bits, odd parity
    repeat (2) @(negedge clk);
    measure(2, 8'h07, 8, bits, tdone, lat);
    chk("par_odd_5b_frame", int'(bits[7:0]), 8'h8E);
    chk("odd_5b_ticks", tdone, 32);

    // reset mid-DATA
    repeat (2) @(negedge clk);
    offer(0, 8'hC3);
    wait_fall(0, lat);
    cyc = tick_total;
    while (tick_total - cyc < 40) @(negedge clk);
    chk("mid_data_busy", int'(busy_w[0]), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_tx_async", int'(tx_w[0]), 1);
    chk("rst_busy", int'(busy_w[0]), 0);
    chk("rst_ready", int'(ready_w[0]), 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_w[0]) nd++;
    end
    chk("rst_no_done", nd, 0);
    chk("rst_idle_tx", int'(tx_w[0]), 1);

    // random traffic: tick every clk, every 4 clk, then irregular
    for (int phase = 0; phase < 3; phase++) begin
      tick_div  = (phase == 0) ? 1 : 4;
      tick_rand = (phase == 2);
      for (int c = 0; c < 6000; c++) begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          if (ready_w[k] && $urandom_range(0, 3) == 0) begin
            valid_drv[k] = 1'b1;
            data_drv[k]  = 8'($urandom);
          end else begin
            valid_drv[k] = 1'b0;
          end
        end
      end
    end
    valid_drv = '0;
    cyc = 0;
    while ((busy_w != 0 || ready_w != 7) && cyc < 5000) begin @(negedge clk); cyc++; end
    chk("drain_idle", int'(busy_w == 0 && ready_w == 7), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
